conway_sweep_ctrl: RTL
======================

Name: conway_sweep_ctrl

Overview:
- Sequences one generation of the Game of Life over a ROWS x (WORDS*20) grid stored as 20-bit words in a source memory.
- Streams 22-bit top/middle/bottom windows into the external 20-cell Conway array and writes its 20-bit result to a destination memory.
- Sits between the host-visible ping-pong grid memories and the combinational array; one start pulse produces one full generation.

Parameters:
- ROWS, 16, grid rows (>=3).
- WORDS, 4, 20-bit words per row (>=2).
- ADDR_W, $clog2(ROWS*WORDS), memory address width; address = row*WORDS + word.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a generation when idle.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse at generation end.
- gen_count  out  16  completed generations; wraps at 65535->0.
- rd_en  out  1  source read strobe.
- rd_addr  out  ADDR_W  source read address.
- rd_data  in  20  source data; valid exactly 1 cycle after rd_en.
- wr_en  out  1  destination write strobe.
- wr_addr  out  ADDR_W  destination address.
- wr_data  out  20  next-state word.
- top_row, middle_row, bottom_row  out  22  windows to the array.
- result  in  20  combinational array output.

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE; busy, done, rd_en, wr_en = 0; addresses, windows and gen_count = 0; window registers cleared.
- Cell mapping: word bit k holds column w*20+k. Window bit j maps to column w*20+j-1, so window[0] = bit 19 of word w-1, window[20:1] = word w, window[21] = bit 0 of word w+1. Out-of-grid cells read as 0.
- Register sets per row lane (top/mid/bot): P (word c-2), Q (word c-1), N (word c).
- FSM states: IDLE, RD_TOP, RD_MID, RD_BOT, CAPT, EMIT, FIN.
- IDLE: start moves to RD_TOP with row=0, c=0, P=Q=0, busy=1. start while busy is ignored.
- Each column step c = 0..WORDS takes 5 cycles:
  - RD_TOP: issue read of row r-1, word c.
  - RD_MID: issue read of row r, word c; capture top into N.
  - RD_BOT: issue read of row r+1, word c; capture mid into N.
  - CAPT: capture bot into N.
  - EMIT: if c>=1, wr_en=1, wr_addr=r*WORDS+c-1, wr_data=result. Then shift P<=Q, Q<=N.
- Suppressed reads (row -1, row ROWS, or c=WORDS): rd_en=0 and the captured N=0. The state still consumes its cycle.
- After EMIT with c=WORDS: if r=ROWS-1 go to FIN, else r++, c=0, P=Q=0, go to RD_TOP.
- FIN: done=1 for one cycle, busy=0, gen_count++, go to IDLE.
- Windows are driven combinationally from P/Q/N and are valid in EMIT. wr_data is taken from result in the same cycle.
- Generation latency: start to done = ROWS*5*(WORDS+1)+1 cycles (401 at defaults). busy is high for exactly ROWS*5*(WORDS+1) cycles.
- Destination writes are strictly ascending in address, one per row word, with no duplicates.

Optional Feature:
- Macro CONWAY_WRAP_EN: toroidal grid.
- With the macro:
  - Row -1 maps to ROWS-1 and row ROWS maps to 0; those reads are issued, not suppressed.
  - Each row begins with an extra prefetch step c=-1 that reads word WORDS-1 into N, with no write; after its shift Q holds word WORDS-1, and P/Q before it are 0.
  - Step c=WORDS reads word 0.
  - Latency becomes ROWS*5*(WORDS+2)+1.
- Without the macro: dead-boundary behaviour as above.

Decomposition:
- conway_pkg: WORD_LEN=20, WIN_LEN=22, state enum type, row/word index typedefs.
- Sub-module conway_window_regs: three P/Q/N lanes with capture/shift/clear controls and window assembly.

Test Plan:
- Blinker: vertical cells at column 30, rows 4-6 -> dest holds horizontal cells at row 5, columns 29-31 (word 1 = 0x0E00). All other words 0. done arrives 401 cycles after start.
- Word-seam: cells at columns 19, 20, 21 in row 8 -> dest row 7 and row 9 have column 20 set. Row 8 keeps only column 20 (word 0 = 0, word 1 = 0x00001).
- Edge dead (no macro): block at rows 0-1, columns 0-1 -> remains unchanged. No rd_en is issued to any row -1 address.
- Wrap (CONWAY_WRAP_EN): cells at (row 0, col 79), (0,0), (0,1) -> vertical blinker at column 0, rows 15, 0, 1. Latency is 481.
- Reset mid-sweep: reset_n low at cycle 200 -> busy=0 immediately and gen_count unchanged. A new start completes normally.
- Back-to-back: three starts, each issued after its preceding done -> gen_count=3. A start pulsed while busy has no effect.

Source files
------------

// File: rtl/conway_pkg.sv
// Shared types for the Conway generation sweeper: cell/window widths,
// the sweep FSM state encoding and the row/word index types.
package conway_pkg;

    localparam int WORD_LEN = 20;
    localparam int WIN_LEN  = 22;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_TOP = 3'd1,
        RD_MID = 3'd2,
        RD_BOT = 3'd3,
        CAPT   = 3'd4,
        EMIT   = 3'd5,
        FIN    = 3'd6
    } state_t;

    typedef logic [15:0] row_idx_t;
    typedef logic [15:0] word_idx_t;

endpackage

// File: rtl/conway_window_regs.sv
// Three row lanes (top/mid/bot), each holding P (word c-2), Q (word c-1)
// and N (word c). Windows are assembled combinationally so they are valid
// as soon as the third capture has landed.
//   window[0]    = P bit 19 (left neighbour column)
//   window[20:1] = Q        (the word being computed)
//   window[21]   = N bit 0  (right neighbour column)
module conway_window_regs
    import conway_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr,
    input  logic                shift,
    input  logic                cap_top,
    input  logic                cap_mid,
    input  logic                cap_bot,
    input  logic [WORD_LEN-1:0] cap_data,
    output logic [WIN_LEN-1:0]  top_row,
    output logic [WIN_LEN-1:0]  middle_row,
    output logic [WIN_LEN-1:0]  bottom_row
);

    // lane index: 0 = top, 1 = middle, 2 = bottom
    logic [2:0][WORD_LEN-1:0] p_q;
    logic [2:0][WORD_LEN-1:0] q_q;
    logic [2:0][WORD_LEN-1:0] n_q;

    // Clear wins over shift, shift wins over capture; the controller never
    // asks for a capture and a shift in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q <= '0;
            q_q <= '0;
            n_q <= '0;
        end else if (clr) begin
            p_q <= '0;
            q_q <= '0;
            n_q <= '0;
        end else if (shift) begin
            p_q <= q_q;
            q_q <= n_q;
        end else begin
            if (cap_top) n_q[0] <= cap_data;
            if (cap_mid) n_q[1] <= cap_data;
            if (cap_bot) n_q[2] <= cap_data;
        end
    end

    assign top_row    = {n_q[0][0], q_q[0], p_q[0][WORD_LEN-1]};
    assign middle_row = {n_q[1][0], q_q[1], p_q[1][WORD_LEN-1]};
    assign bottom_row = {n_q[2][0], q_q[2], p_q[2][WORD_LEN-1]};

endmodule

// File: rtl/conway_sweep_ctrl.sv
// One Game of Life generation per start pulse: reads the source grid three
// rows at a time, feeds 22-bit windows to the external combinational array
// and writes each 20-bit result word to the destination grid in ascending
// address order.
// Build option: define CONWAY_WRAP_EN for a toroidal grid (edges wrap,
// plus one prefetch column step per row); otherwise out-of-grid cells are 0.
//
// Memory handshake: rd_en/rd_addr are a single-cycle request and rd_data is
// consumed exactly one cycle later with no back-pressure; wr_en/wr_addr/
// wr_data are a single-cycle write that the destination always accepts.
module conway_sweep_ctrl
    import conway_pkg::*;
#(
    parameter int ROWS   = 16,
    parameter int WORDS  = 4,
    parameter int ADDR_W = $clog2(ROWS*WORDS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [15:0]         gen_count,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [WORD_LEN-1:0] rd_data,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [WORD_LEN-1:0] wr_data,
    output logic [WIN_LEN-1:0]  top_row,
    output logic [WIN_LEN-1:0]  middle_row,
    output logic [WIN_LEN-1:0]  bottom_row,
    input  logic [WORD_LEN-1:0] result,
    output state_t              state_dbg
);

`ifdef CONWAY_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    localparam row_idx_t  LAST_ROW  = row_idx_t'(ROWS - 1);
    localparam word_idx_t LAST_COL  = word_idx_t'(WORDS);
    localparam word_idx_t LAST_WORD = word_idx_t'(WORDS - 1);

    state_t    state_q, state_d;
    row_idx_t  row_q, row_d;
    word_idx_t col_q, col_d;
    logic      pre_q, pre_d;     // prefetch step (c = -1), wrap build only
    logic [15:0] gen_q;
    logic      rd_vld_q;         // a read was issued last cycle

    logic      clr, shift, cap_top, cap_mid, cap_bot;
    logic [WORD_LEN-1:0] cap_data;

    row_idx_t  row_up, row_dn;
    word_idx_t rd_word;
    logic      word_ok, up_ok, dn_ok;

    function automatic logic [ADDR_W-1:0] mk_addr(input row_idx_t r, input word_idx_t w);
        logic [31:0] a;
        a = 32'(r) * 32'(WORDS) + 32'(w);
        return a[ADDR_W-1:0];
    endfunction

    // Neighbour rows and read word, with wrap or suppression at the edges.
    assign row_up  = (row_q == '0) ? LAST_ROW : row_q - row_idx_t'(1);
    assign row_dn  = (row_q == LAST_ROW) ? '0 : row_q + row_idx_t'(1);
    assign rd_word = pre_q ? LAST_WORD : ((col_q == LAST_COL) ? '0 : col_q);
    assign word_ok = WRAP_EN || (col_q != LAST_COL);
    assign up_ok   = word_ok && (WRAP_EN || (row_q != '0));
    assign dn_ok   = word_ok && (WRAP_EN || (row_q != LAST_ROW));

    // A suppressed read captures zero: the data bus is ignored.
    assign cap_data = rd_vld_q ? rd_data : '0;

    assign gen_count = gen_q;
    assign state_dbg = state_q;

    // Sweep state, position counters, generation counter, read-valid pipe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            pre_q    <= 1'b0;
            gen_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            pre_q    <= pre_d;
            rd_vld_q <= rd_en;
            if (state_q == FIN) gen_q <= gen_q + 16'd1;
        end
    end

    // Next state, memory strobes and window-register controls.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        pre_d   = pre_q;
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clr     = 1'b0;
        shift   = 1'b0;
        cap_top = 1'b0;
        cap_mid = 1'b0;
        cap_bot = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_TOP;
                    row_d   = '0;
                    col_d   = '0;
                    pre_d   = WRAP_EN;
                    clr     = 1'b1;
                end
            end
            RD_TOP: begin
                busy    = 1'b1;
                rd_en   = up_ok;
                rd_addr = up_ok ? mk_addr(row_up, rd_word) : '0;
                state_d = RD_MID;
            end
            RD_MID: begin
                busy    = 1'b1;
                rd_en   = word_ok;
                rd_addr = word_ok ? mk_addr(row_q, rd_word) : '0;
                cap_top = 1'b1;
                state_d = RD_BOT;
            end
            RD_BOT: begin
                busy    = 1'b1;
                rd_en   = dn_ok;
                rd_addr = dn_ok ? mk_addr(row_dn, rd_word) : '0;
                cap_mid = 1'b1;
                state_d = CAPT;
            end
            CAPT: begin
                busy    = 1'b1;
                cap_bot = 1'b1;
                state_d = EMIT;
            end
            EMIT: begin
                busy  = 1'b1;
                shift = 1'b1;
                if (!pre_q && (col_q != '0)) begin
                    wr_en   = 1'b1;
                    wr_addr = mk_addr(row_q, col_q - word_idx_t'(1));
                    wr_data = result;
                end
                if (pre_q) begin
                    pre_d   = 1'b0;
                    state_d = RD_TOP;
                end else if (col_q == LAST_COL) begin
                    if (row_q == LAST_ROW) begin
                        state_d = FIN;
                    end else begin
                        row_d   = row_q + row_idx_t'(1);
                        col_d   = '0;
                        pre_d   = WRAP_EN;
                        clr     = 1'b1;
                        state_d = RD_TOP;
                    end
                end else begin
                    col_d   = col_q + word_idx_t'(1);
                    state_d = RD_TOP;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    conway_window_regs u_win (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (clr),
        .shift      (shift),
        .cap_top    (cap_top),
        .cap_mid    (cap_mid),
        .cap_bot    (cap_bot),
        .cap_data   (cap_data),
        .top_row    (top_row),
        .middle_row (middle_row),
        .bottom_row (bottom_row)
    );

endmodule
